// File: rtl/sar_pkg.sv
// ---------------------------------------------------------------------------
// sar_pkg : shared code width and averaging FSM state encoding for sar_avg
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sar_pkg;

  localparam int CODE_W = 8;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sar_result_fifo.sv
// ---------------------------------------------------------------------------
// sar_result_fifo : small synchronous FIFO for averaged codes; head output
//                   holds the last popped word while empty.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sar_result_fifo
  import sar_pkg::*;
#(
  parameter int WIDTH = CODE_W,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_clear,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_last;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == c_DEPTH);
  assign w_pop_ok  = i_pop && !o_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_data    = o_empty ? r_last : r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok && !i_clear) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sar_avg.sv
// ---------------------------------------------------------------------------
// sar_avg : averages 2^OSR_LOG2 SAR conversions per output word into a FIFO.
//           Define SAR_AVG_ROUND_EN for round-half-up instead of truncation.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sar_avg
  import sar_pkg::*;
#(
  parameter int OSR_LOG2   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              clear,
  input  logic [CODE_W-1:0] sar_code,
  input  logic              sar_done,
  output logic [CODE_W-1:0] avg_data,
  output logic              avg_valid,
  input  logic              avg_ready,
  output logic [3:0]        fifo_count,
  output logic              overflow
);

  localparam int ACC_W  = CODE_W + OSR_LOG2;
  localparam int CNT_W  = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'((1 << OSR_LOG2) - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ACC_W-1:0]    r_acc;
  logic [ACC_W-1:0]    w_acc_base;
  logic [ACC_W-1:0]    w_acc_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_base;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                r_done_q;
  logic                r_overflow;
  logic                w_capture;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CODE_W-1:0]   w_result;
  logic [CODE_W-1:0]   w_fifo_data;
  logic [FCNT_W-1:0]   w_fifo_count;

  assign w_capture = ena && sar_done && !r_done_q;
  assign w_push    = (r_state == EMIT) && ena && !clear;
  assign w_pop     = avg_ready && !w_empty;

  // EMIT restarts from zero, so a capture landing there becomes sample one.
  always_comb begin
    w_acc_base  = (r_state == EMIT) ? '0 : r_acc;
    w_cnt_base  = (r_state == EMIT) ? '0 : r_cnt;
    w_state_nxt = ACCUM;
    w_acc_nxt   = w_acc_base;
    w_cnt_nxt   = w_cnt_base;
    if (w_capture) begin
      w_acc_nxt = w_acc_base + ACC_W'(sar_code);
      if (w_cnt_base == c_LAST) begin
        w_state_nxt = EMIT;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt = w_cnt_base + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ACCUM;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_state    <= ACCUM;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (ena) begin
        r_state <= w_state_nxt;
        r_acc   <= w_acc_nxt;
        r_cnt   <= w_cnt_nxt;
      end
      if (w_push && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done_q <= 1'b0;
    end else if (ena) begin
      r_done_q <= sar_done;
    end
  end

  generate
    if (OSR_LOG2 == 0) begin : g_pass
      assign w_result = r_acc[CODE_W-1:0];
    end else begin : g_avg
      logic [ACC_W-1:0] w_sum;
`ifdef SAR_AVG_ROUND_EN
      assign w_sum = r_acc + ACC_W'(1 << (OSR_LOG2 - 1));
`else
      assign w_sum = r_acc;
`endif
      assign w_result = w_sum[ACC_W-1:OSR_LOG2];
    end
  endgenerate

  sar_result_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_push  (w_push),
    .i_data  (w_result),
    .i_pop   (avg_ready),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_count)
  );

  assign avg_data   = w_fifo_data;
  assign avg_valid  = !w_empty;
  assign fifo_count = 4'(w_fifo_count);
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: doc/sar_avg.md
SAR_AVG -- requirements
Module: sar_avg

Interface
REQ-001 Parameter OSR_LOG2, default 2, log2 of samples averaged per output word (legal 0..4).
REQ-002 Parameter FIFO_DEPTH, default 4, number of averaged words buffered (power of two, 2..8).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 ena  input  1  block enable; low = ignore new conversions and hold all state.
REQ-006 clear  input  1  synchronous flush of accumulator, sample count, FIFO and overflow flag.
REQ-007 sar_code  input  8  conversion result from the upstream 8-bit SAR (uo_out).
REQ-008 sar_done  input  1  end-of-conversion level from the upstream SAR (uio_out[0]); sar_code valid while high.
REQ-009 avg_data  output  8  head-of-FIFO averaged code.
REQ-010 avg_valid  output  1  FIFO non-empty.
REQ-011 avg_ready  input  1  consumer accepts avg_data when avg_valid && avg_ready on a rising clk edge.
REQ-012 fifo_count  output  4  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-013 overflow  output  1  sticky; set when an averaged word is dropped.

Function
REQ-014 Capture event = rising edge of sar_done (sar_done=1, registered previous sar_done=0) with ena=1; held-high sar_done yields exactly one capture.
REQ-015 On capture, acc <= acc + sar_code (acc width 8+OSR_LOG2, never overflows) and sample count increments.
REQ-016 FSM states: ACCUM (collecting), EMIT (one cycle, push result); ACCUM -> EMIT on the capture that completes 2^OSR_LOG2 samples; EMIT -> ACCUM unconditionally with acc and count zeroed.
REQ-017 Captures arriving in EMIT are accumulated as the first sample of the next average (no sample loss).
REQ-018 Result = acc >> OSR_LOG2 (see REQ-028 for rounding); OSR_LOG2=0 passes sar_code through unchanged.
REQ-019 Latency: final capture at edge T, FIFO push at edge T+1, avg_valid high from T+1 with avg_data = result.
REQ-020 Pop on avg_valid && avg_ready; avg_data and fifo_count update the same edge.
REQ-021 Push while full with no simultaneous pop: word dropped, FIFO unchanged, overflow set.
REQ-022 Push while full with simultaneous pop: both succeed, fifo_count unchanged, no overflow.
REQ-023 Pop while empty: ignored, fifo_count stays 0, avg_data holds last value.
REQ-024 FIFO read/write pointers wrap modulo FIFO_DEPTH.
REQ-025 clear has priority over capture, push and pop in the same cycle; takes effect at next edge.
REQ-026 ena=0: no captures, FSM frozen, pops still honoured.

Reset
REQ-027 rst_n low: state ACCUM, acc=0, count=0, registered sar_done=0, FIFO empty, avg_data=0, avg_valid=0, fifo_count=0, overflow=0; mid-average partial sums discarded.

Configuration
REQ-028 SAR_AVG_ROUND_EN defined: result = (acc + 2^(OSR_LOG2-1)) >> OSR_LOG2 (round-half-up, max 255, no saturation logic needed); undefined: truncation; OSR_LOG2=0 unaffected either way.

Structure
REQ-029 Shared package sar_pkg holds CODE_W=8 and the FSM state enum (ACCUM, EMIT).
REQ-030 FIFO is a sub-module sar_result_fifo (parameterised width/depth, push/pop/full/empty/count, clear).

Verification
REQ-031 OSR_LOG2=2, done pulses with codes 10,11,11,11 -> avg_data=11 with SAR_AVG_ROUND_EN, 10 without; avg_valid rises one edge after 4th capture.
REQ-032 sar_done held high 5 cycles with code 200 -> exactly one capture; count advances by 1.
REQ-033 avg_ready=0, 5 full averages of code 0x80, FIFO_DEPTH=4 -> fifo_count=4, overflow=1, four reads return 0x80.
REQ-034 FIFO full, push and pop same edge -> fifo_count stays 4, overflow stays 0, new word at tail.
REQ-035 rst_n low after 2 of 4 samples, then 4 captures of 50 -> single output 50 (partial sum discarded).
REQ-036 clear asserted with FIFO holding 3 words and overflow=1 -> next edge fifo_count=0, avg_valid=0, overflow=0.
